// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Event counters hold at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard detector: flags when the load in EX writes a register read by ID.
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rt,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   output logic       load_use
);

   // $zero never carries a real dependency.
   assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage core with data-memory handshake and wait timeout.
// Optional PIPE_CTRL_PERF_EN adds saturating stall and flush cycle counters.
//
// state       | meaning
// ST_RUN      | normal flow; hazards resolved combinationally
// ST_MEM_WAIT | data access outstanding, waiting for ack
// ST_HALT     | memory never acknowledged; frozen until RESET
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_IDEX_MemRead,
   input  logic [4:0]  I_IDEX_Rt,
   input  logic [4:0]  I_IFID_Rs,
   input  logic [4:0]  I_IFID_Rt,
   input  logic        I_EX_BranchTaken,
   input  logic        I_EXMEM_MemReq,
   input  logic        I_DMEM_Ack,
   output logic        O_DMEM_Req,
   output logic        O_PC_En,
   output logic        O_IFID_En,
   output logic        O_IDEX_En,
   output logic        O_EXMEM_En,
   output logic        O_MEMWB_En,
   output logic        O_IFID_Flush,
   output logic        O_IDEX_Flush,
   output logic        O_MEMWB_Flush,
   output logic        O_Timeout,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] O_StallCnt,
   output logic [31:0] O_FlushCnt,
`endif
   output logic [1:0]  O_State
);

   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic load_use;
   logic active;
   logic dmem_req;
   logic mem_stall;

   pipe_hazard_detect u_hazard (
      .idex_mem_read (I_IDEX_MemRead),
      .idex_rt       (I_IDEX_Rt),
      .ifid_rs       (I_IFID_Rs),
      .ifid_rt       (I_IFID_Rt),
      .load_use      (load_use)
   );

   assign active    = !RESET && (state_q != ST_HALT);
   assign dmem_req  = active && (((state_q == ST_RUN) && I_EXMEM_MemReq) ||
                                 (state_q == ST_MEM_WAIT));
   // An ack in the request cycle (or in the wait state) releases the stall at once.
   assign mem_stall = dmem_req && !I_DMEM_Ack;

   always_comb begin
      O_DMEM_Req    = dmem_req;
      O_PC_En       = 1'b0;
      O_IFID_En     = 1'b0;
      O_IDEX_En     = 1'b0;
      O_EXMEM_En    = 1'b0;
      O_MEMWB_En    = 1'b0;
      O_IFID_Flush  = 1'b0;
      O_IDEX_Flush  = 1'b0;
      O_MEMWB_Flush = 1'b0;
      if (active) begin
         if (mem_stall) begin
            O_MEMWB_En    = 1'b1;
            O_MEMWB_Flush = 1'b1;
         end else begin
            O_PC_En    = 1'b1;
            O_IFID_En  = 1'b1;
            O_IDEX_En  = 1'b1;
            O_EXMEM_En = 1'b1;
            O_MEMWB_En = 1'b1;
            if (I_EX_BranchTaken) begin
               O_IFID_Flush = 1'b1;
               O_IDEX_Flush = 1'b1;
            end else if (load_use) begin
               O_PC_En      = 1'b0;
               O_IFID_En    = 1'b0;
               O_IDEX_Flush = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_RUN: begin
            if (I_EXMEM_MemReq && !I_DMEM_Ack) begin
               state_d = ST_MEM_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (I_DMEM_Ack) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_TC) begin
               state_d   = ST_HALT;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HALT: timeout_d = 1'b1;
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Reset overrides the visible status immediately, not one edge later.
   assign O_State   = RESET ? ST_RUN : state_q;
   assign O_Timeout = !RESET && timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic        stall_evt, flush_evt;

   assign stall_evt = mem_stall || (active && !I_EX_BranchTaken && load_use);
   assign flush_evt = active && !mem_stall && I_EX_BranchTaken;

   always_comb begin
      stall_cnt_d = stall_evt ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = flush_evt ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign O_StallCnt = stall_cnt_q;
   assign O_FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected control vectors are queued as stimulus is driven.
module tb_pipe_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        idex_mr;
   logic [4:0]  idex_rt, ifid_rs, ifid_rt;
   logic        br, mem_req, ack;
   logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_fl, idex_fl, memwb_fl, timeout;
   logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .CLK              (clk),
      .RESET            (rst),
      .I_IDEX_MemRead   (idex_mr),
      .I_IDEX_Rt        (idex_rt),
      .I_IFID_Rs        (ifid_rs),
      .I_IFID_Rt        (ifid_rt),
      .I_EX_BranchTaken (br),
      .I_EXMEM_MemReq   (mem_req),
      .I_DMEM_Ack       (ack),
      .O_DMEM_Req       (dmem_req),
      .O_PC_En          (pc_en),
      .O_IFID_En        (ifid_en),
      .O_IDEX_En        (idex_en),
      .O_EXMEM_En       (exmem_en),
      .O_MEMWB_En       (memwb_en),
      .O_IFID_Flush     (ifid_fl),
      .O_IDEX_Flush     (idex_fl),
      .O_MEMWB_Flush    (memwb_fl),
      .O_Timeout        (timeout),
`ifdef PIPE_CTRL_PERF_EN
      .O_StallCnt       (stall_cnt),
      .O_FlushCnt       (flush_cnt),
`endif
      .O_State          (state)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [11:0] exp_q[$];

   // reference model state
   logic [1:0]  m_st;
   int          m_cnt;
   bit          m_to;
   logic [31:0] m_stall, m_flush;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // vector: {req, pc, ifid, idex, exmem, memwb en, ifid/idex/memwb flush, timeout, state}
   function automatic logic [11:0] model_out(bit r, bit req, bit a, bit b, bit lu);
      bit         act, dreq, ms;
      logic [4:0] en;
      logic [2:0] fl;
      act  = !r && (m_st != 2'd2);
      dreq = act && ((m_st == 2'd0 && req) || m_st == 2'd1);
      ms   = dreq && !a;
      if (!act)     begin en = 5'b00000; fl = 3'b000; end
      else if (ms)  begin en = 5'b00001; fl = 3'b001; end
      else if (b)   begin en = 5'b11111; fl = 3'b110; end
      else if (lu)  begin en = 5'b00111; fl = 3'b010; end
      else          begin en = 5'b11111; fl = 3'b000; end
      return {dreq, en, fl, (r ? 1'b0 : m_to), (r ? 2'd0 : m_st)};
   endfunction

   task automatic model_step(bit r, bit req, bit a, bit b, bit lu);
      bit act, ms;
      act = !r && (m_st != 2'd2);
      ms  = act && ((m_st == 2'd0 && req) || m_st == 2'd1) && !a;
      if (r) begin
         m_st = 2'd0; m_cnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (act) begin
            if (ms)                    m_stall = (m_stall == '1) ? m_stall : m_stall + 1;
            else if (b)                m_flush = (m_flush == '1) ? m_flush : m_flush + 1;
            else if (lu)               m_stall = (m_stall == '1) ? m_stall : m_stall + 1;
         end
         case (m_st)
            2'd0: if (req && !a) begin m_st = 2'd1; m_cnt = 1; end
            2'd1: begin
               if (a)                 begin m_st = 2'd0; m_cnt = 0; end
               else if (m_cnt == TO)  begin m_st = 2'd2; m_to = 1; end
               else                   m_cnt++;
            end
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input string tag, input bit r, input bit mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input bit b,
                      input bit req, input bit a);
      bit          lu;
      logic [11:0] got, exp;
      rst = r; idex_mr = mr; idex_rt = ert; ifid_rs = rs; ifid_rt = rt;
      br = b; mem_req = req; ack = a;
      lu = mr && (ert != 5'd0) && (ert == rs || ert == rt);
      exp_q.push_back(model_out(r, req, a, b, lu));
      @(negedge clk);
      got = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_fl, idex_fl, memwb_fl, timeout, state};
      exp = exp_q.pop_front();
      check(tag, {20'd0, got}, {20'd0, exp});
`ifdef PIPE_CTRL_PERF_EN
      check({tag, "_stallcnt"}, stall_cnt, m_stall);
      check({tag, "_flushcnt"}, flush_cnt, m_flush);
`endif
      model_step(r, req, a, b, lu);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; idex_mr = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
      br = 0; mem_req = 0; ack = 0;
      m_st = 0; m_cnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
      @(posedge clk); #1;

      //    tag          rst mr ert rs rt br req ack
      cyc("reset0",      1, 0, 0, 0, 0, 0, 0, 0);
      cyc("reset_inputs",1, 1, 8, 8, 0, 1, 1, 0);
      cyc("idle",        0, 0, 0, 0, 0, 0, 0, 0);
      cyc("lu_rs",       0, 1, 8, 8, 3, 0, 0, 0);
      cyc("lu_rt0",      0, 1, 0, 0, 0, 0, 0, 0);
      cyc("lu_rt",       0, 1, 9, 3, 9, 0, 0, 0);
      cyc("lu_nomatch",  0, 1, 9, 3, 4, 0, 0, 0);
      cyc("zero_wait",   0, 0, 0, 0, 0, 0, 1, 1);
      cyc("lat3_req",    0, 0, 0, 0, 0, 0, 1, 0);
      cyc("lat3_wait",   0, 0, 0, 0, 0, 0, 1, 0);
      cyc("lat3_ack",    0, 0, 0, 0, 0, 0, 1, 1);
      cyc("lat3_after",  0, 0, 0, 0, 0, 0, 0, 0);
      cyc("br_stall_req",0, 0, 0, 0, 0, 1, 1, 0);
      cyc("br_stall_w",  0, 0, 0, 0, 0, 1, 1, 0);
      cyc("br_release",  0, 0, 0, 0, 0, 1, 1, 1);
      cyc("br_and_lu",   0, 1, 7, 7, 7, 1, 0, 0);
      cyc("ack_no_req",  0, 0, 0, 0, 0, 0, 0, 1);
      cyc("rst_mid_req", 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("rst_mid_w",   0, 0, 0, 0, 0, 0, 1, 0);
      cyc("rst_mid",     1, 0, 0, 0, 0, 0, 1, 0);
      cyc("rst_mid_run", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("to_req",      0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= TO; i++)
         cyc($sformatf("to_wait%0d", i), 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("halt0",       0, 1, 8, 8, 0, 1, 1, 0);
      cyc("halt_ack",    0, 0, 0, 0, 0, 0, 1, 1);
      cyc("halt_rst",    1, 0, 0, 0, 0, 0, 0, 0);
      cyc("post_halt",   0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         cyc("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0));
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
